// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM states and
// duty-cycle scaling used by the top level and the duty divider.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  // Duty is reported in percent, so 0..100 fits in 7 bits.
  localparam int DUTY_SCALE = 100;
  localparam int DUTY_W     = 7;

  // Extra dividend bits needed to hold high_time * DUTY_SCALE.
  localparam int DUTY_EXT_W = 7;

endpackage : pwm_capture_pkg

// File: rtl/pwm_duty_divider.sv
// Restoring divider, one quotient bit per cycle: one load cycle, then
// DIVIDEND_W iterations; done pulses when the quotient is final.
module pwm_duty_divider #(
  parameter int DIVIDEND_W = 27,
  parameter int DIVISOR_W  = 20,
  parameter int QUOT_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int ITER_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    diff;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    iter_d = iter_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[DIVIDEND_W-1]};
    diff   = trial - {1'b0, dvs_q};

    if (abort) begin
      busy_d = 1'b0;
      iter_d = '0;
    end else if (busy_q) begin
      // Remainder stays below the divisor, so the difference fits DIVISOR_W.
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = diff[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
      end
      iter_d = iter_q - ITER_W'(1);
      if (iter_q == ITER_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      rem_d  = '0;
      dvs_d  = divisor;
      quo_d  = dividend;
      iter_d = ITER_W'(DIVIDEND_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q[QUOT_W-1:0];

endmodule : pwm_duty_divider

// File: rtl/pwm_capture.sv
// PWM measurement: period, high time and duty percent of pwm_in.
// Optional glitch filter on the synced input: define PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              overrun
);

  localparam int DIVIDEND_W = CNT_W + DUTY_EXT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  logic                   level;
  logic                   level_q;
  logic                   rise;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       samp_per_q, samp_per_d;
  logic [CNT_W-1:0]       samp_high_q, samp_high_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic [DUTY_W-1:0]      duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   stuck_q, stuck_d;
  logic                   overrun_q, overrun_d;

  logic                   div_start;
  logic                   div_abort;
  logic                   div_busy;
  logic                   div_done;
  logic [DUTY_W-1:0]      div_quo;
  logic [DIVIDEND_W-1:0]  div_dividend;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // The filtered level flips only after FILTER_LEN consecutive disagreeing cycles.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (synced != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        filt_d = synced;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = synced;
`endif

  assign rise = level & ~level_q;

  assign div_dividend = DIVIDEND_W'(high_cnt_q) * DIVIDEND_W'(DUTY_SCALE);

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    high_cnt_d  = high_cnt_q;
    samp_per_d  = samp_per_q;
    samp_high_d = samp_high_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    overrun_d   = overrun_q;
    div_start   = 1'b0;
    div_abort   = !enable || (state_q == ST_TIMEOUT);

    if (!enable) begin
      state_d    = ST_ARM;
      per_cnt_d  = '0;
      high_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_ARM: begin
          if (rise) begin
            state_d    = ST_MEASURE;
            per_cnt_d  = CNT_W'(1);
            high_cnt_d = CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            // Reload on the rise itself so consecutive periods lose no cycle.
            per_cnt_d  = CNT_W'(1);
            high_cnt_d = CNT_W'(1);
            if (!div_busy) begin
              div_start   = 1'b1;
              samp_per_d  = per_cnt_q;
              samp_high_d = high_cnt_q;
            end else begin
              overrun_d = 1'b1;
            end
          end else if (per_cnt_q == CNT_MAX) begin
            state_d    = ST_TIMEOUT;
            per_cnt_d  = '0;
            high_cnt_d = '0;
          end else begin
            per_cnt_d = per_cnt_q + CNT_W'(1);
            if (level) begin
              high_cnt_d = high_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_TIMEOUT: begin
          state_d     = ST_ARM;
          period_d    = '0;
          high_time_d = '0;
          duty_d      = level ? DUTY_W'(DUTY_SCALE) : '0;
          stuck_d     = 1'b1;
          valid_d     = 1'b1;
        end
        default: begin
          state_d = ST_ARM;
        end
      endcase

      // A timeout in the same cycle owns the outputs; its abort drops the result.
      if (div_done && (state_q != ST_TIMEOUT)) begin
        period_d    = samp_per_q;
        high_time_d = samp_high_q;
        duty_d      = div_quo;
        stuck_d     = 1'b0;
        valid_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      state_q     <= ST_ARM;
      per_cnt_q   <= '0;
      high_cnt_q  <= '0;
      samp_per_q  <= '0;
      samp_high_q <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level;
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      high_cnt_q  <= high_cnt_d;
      samp_per_q  <= samp_per_d;
      samp_high_q <= samp_high_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      overrun_q   <= overrun_d;
    end
  end

  pwm_duty_divider #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (CNT_W),
    .QUOT_W     (DUTY_W)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (per_cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign period    = period_q;
  assign high_time = high_time_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign overrun   = overrun_q;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a CNT_W=20 instance for the main function
// and a CNT_W=12 instance for timeout and overrun.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int CNT_A = 20;
  localparam int CNT_B = 12;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int EDGE_LAT = SYNC + FILT + 1;
`else
  localparam int EDGE_LAT = SYNC + 1;
`endif
  localparam int LAT_A = EDGE_LAT + CNT_A + 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic pin_a = 1'b0;
  logic pin_b = 1'b0;

  logic [CNT_A-1:0]  a_period, a_high;
  logic [DUTY_W-1:0] a_duty;
  logic              a_valid, a_stuck, a_overrun;
  logic [CNT_B-1:0]  b_period, b_high;
  logic [DUTY_W-1:0] b_duty;
  logic              b_valid, b_stuck, b_overrun;

  pwm_capture #(.CNT_W(CNT_A), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .pwm_in(pin_a),
    .period(a_period), .high_time(a_high), .duty(a_duty),
    .valid(a_valid), .stuck(a_stuck), .overrun(a_overrun)
  );

  pwm_capture #(.CNT_W(CNT_B), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .pwm_in(pin_b),
    .period(b_period), .high_time(b_high), .duty(b_duty),
    .valid(b_valid), .stuck(b_stuck), .overrun(b_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int per;
    int hi;
    int du;
    int at;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];

  always @(negedge clk) begin : mon_a
    rec_t r;
    if (a_valid === 1'b1) begin
      r.per = int'(a_period);
      r.hi  = int'(a_high);
      r.du  = int'(a_duty);
      r.at  = cyc;
      qa.push_back(r);
    end
  end

  always @(negedge clk) begin : mon_b
    rec_t r;
    if (b_valid === 1'b1) begin
      r.per = int'(b_period);
      r.hi  = int'(b_high);
      r.du  = int'(b_duty);
      r.at  = cyc;
      qb.push_back(r);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rec(input string tag, input rec_t r, input int per, input int hi, input int du);
    check({tag, "_period"}, 64'(r.per), 64'(per));
    check({tag, "_high"},   64'(r.hi),  64'(hi));
    check({tag, "_duty"},   64'(r.du),  64'(du));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input int hi, input int lo);
    pin_a = 1'b1;
    tick(hi);
    pin_a = 1'b0;
    tick(lo);
  endtask

  task automatic pulse_b(input int hi, input int lo);
    pin_b = 1'b1;
    tick(hi);
    pin_b = 1'b0;
    tick(lo);
  endtask

  task automatic rearm();
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
  endtask

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int T3_HI = 146, T3_LO = 4, T3_DUTY = 97;
  localparam int G_N = 3;
  int g_per[4] = '{200, 200, 200, 0};
  int g_hi[4]  = '{100, 100, 100, 0};
  int g_du[4]  = '{50, 50, 50, 0};
`else
  localparam int T3_HI = 149, T3_LO = 1, T3_DUTY = 99;
  localparam int G_N = 4;
  int g_per[4] = '{200, 42, 158, 200};
  int g_hi[4]  = '{100, 40, 58, 100};
  int g_du[4]  = '{50, 95, 36, 50};
`endif

  initial begin
    int r1;
    int r2;

    // Reset state
    tick(3);
    check("rst_period",  64'(a_period),  64'(0));
    check("rst_high",    64'(a_high),    64'(0));
    check("rst_duty",    64'(a_duty),    64'(0));
    check("rst_valid",   64'(a_valid),   64'(0));
    check("rst_stuck",   64'(a_stuck),   64'(0));
    check("rst_overrun", 64'(a_overrun), 64'(0));
    check("rst_b_stuck", 64'(b_stuck),   64'(0));
    rst = 1'b1;
    enable = 1'b1;
    tick(5);

    // 200/50 stream: first valid LAT_A after the second rise, then every 200
    qa.delete();
    pulse_a(50, 150);
    r1 = cyc;
    repeat (4) pulse_a(50, 150);
    tick(50);
    check("t1_count", 64'(qa.size()), 64'(4));
    for (int i = 0; i < qa.size(); i++) check_rec("t1", qa[i], 200, 50, 25);
    if (qa.size() > 0) check("t1_latency", 64'(qa[0].at - r1), 64'(LAT_A));
    for (int i = 1; i < qa.size(); i++) check("t1_interval", 64'(qa[i].at - qa[i-1].at), 64'(200));

    // Truncating duty: 300/100 -> 33
    rearm();
    qa.delete();
    repeat (3) pulse_a(100, 200);
    tick(10);
    check("t2_count", 64'(qa.size()), 64'(2));
    for (int i = 0; i < qa.size(); i++) check_rec("t2", qa[i], 300, 100, 33);

    // Minimal low phase
    rearm();
    qa.delete();
    repeat (3) pulse_a(T3_HI, T3_LO);
    tick(40);
    check("t3_count", 64'(qa.size()), 64'(2));
    for (int i = 0; i < qa.size(); i++) check_rec("t3", qa[i], T3_HI + T3_LO, T3_HI, T3_DUTY);
    check("t3_overrun", 64'(a_overrun), 64'(0));

    // Timeout on the 12-bit instance with the input held high
    qb.delete();
    pin_b = 1'b1;
    for (int i = 0; i < 5000 && qb.size() == 0; i++) tick(1);
    check("b_to_count", 64'(qb.size()), 64'(1));
    if (qb.size() > 0) check_rec("b_to", qb[0], 0, 0, 100);
    check("b_to_stuck", 64'(b_stuck), 64'(1));
    tick(3);
    check("b_to_single", 64'(qb.size()), 64'(1));
    pin_b = 1'b0;
    tick(30);
    qb.delete();
    repeat (3) pulse_b(10, 30);
    tick(30);
    check("b_rec_count", 64'(qb.size()), 64'(2));
    for (int i = 0; i < qb.size(); i++) check_rec("b_rec", qb[i], 40, 10, 25);
    check("b_rec_stuck", 64'(b_stuck), 64'(0));

    // Overrun: period 10 against a 20-cycle divider keeps every other sample
    check("b_ovr_before", 64'(b_overrun), 64'(0));
    rearm();
    qb.delete();
    repeat (7) pulse_b(5, 5);
    tick(40);
    check("b_ovr_count", 64'(qb.size()), 64'(3));
    for (int i = 0; i < qb.size(); i++) check_rec("b_ovr", qb[i], 10, 5, 50);
    check("b_ovr_set", 64'(b_overrun), 64'(1));
    rearm();
    tick(5);
    check("b_ovr_sticky", 64'(b_overrun), 64'(1));

    // Enable low mid-period holds outputs; re-enable needs a full period
    rearm();
    qa.delete();
    pulse_a(50, 150);
    pulse_a(50, 150);
    pin_a = 1'b1;
    tick(50);
    pin_a = 1'b0;
    tick(50);
    check("t4_pre_count", 64'(qa.size()), 64'(2));
    qa.delete();
    enable = 1'b0;
    tick(30);
    check("t4_hold_period", 64'(a_period), 64'(200));
    check("t4_hold_high",   64'(a_high),   64'(50));
    check("t4_hold_duty",   64'(a_duty),   64'(25));
    check("t4_hold_none",   64'(qa.size()), 64'(0));
    enable = 1'b1;
    tick(70);
    pulse_a(50, 150);
    check("t4_rearm_none", 64'(qa.size()), 64'(0));
    r2 = cyc;
    pulse_a(50, 150);
    check("t4_count", 64'(qa.size()), 64'(1));
    if (qa.size() > 0) begin
      check_rec("t4", qa[0], 200, 50, 25);
      check("t4_latency", 64'(qa[0].at - r2), 64'(LAT_A));
    end

    // Reset pulse during a division
    rearm();
    qa.delete();
    pulse_a(50, 150);
    pin_a = 1'b1;
    tick(EDGE_LAT + 10);
    rst = 1'b0;
    tick(1);
    check("t5_period",  64'(a_period), 64'(0));
    check("t5_high",    64'(a_high),   64'(0));
    check("t5_duty",    64'(a_duty),   64'(0));
    check("t5_valid",   64'(a_valid),  64'(0));
    check("t5_b_ovr",   64'(b_overrun), 64'(0));
    rst = 1'b1;
    tick(40);
    pin_a = 1'b0;
    tick(60);
    check("t5_no_valid", 64'(qa.size()), 64'(0));

    // 2-cycle glitch 40 cycles into a 100-cycle high phase
    rearm();
    qa.delete();
    pulse_a(100, 100);
    pin_a = 1'b1;
    tick(40);
    pin_a = 1'b0;
    tick(2);
    pin_a = 1'b1;
    tick(58);
    pin_a = 1'b0;
    tick(100);
    pulse_a(100, 100);
    pulse_a(100, 100);
    tick(40);
    check("t6_count", 64'(qa.size()), 64'(G_N));
    for (int i = 0; i < qa.size() && i < G_N; i++) check_rec("t6", qa[i], g_per[i], g_hi[i], g_du[i]);
    check("t6_overrun", 64'(a_overrun), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with total=%0d", total);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pwm_capture
